serial_adder2_seq: RTL and testbench

//  Sequencer that adds two WIDTH-bit operands plus carry-in on one shared 2-bit adder slice (adder2).

---
 rtl/serial_adder2_seq.sv | 141 ++++++++++++++
 tb/tb_serial_adder2_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder2_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder2_seq
// Purpose  : WIDTH-bit adder that reuses one 2-bit adder slice over WIDTH/2
//            cycles, LSB pair first, with valid/ready on both sides.
//            Optional two's-complement overflow output: SERIAL_ADD_OVF_EN.
// Revision : 1.0
// ============================================================================
module serial_adder2_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int N    = WIDTH / 2;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDXW-1:0] c_LAST = IDXW'(N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_c1;
  logic             w_s0;
  logic             w_s1;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  // Operands shift right each RUN cycle, so the active pair is always bits [1:0].
  assign w_s0   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c1   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_s1   = r_a[1] ^ r_b[1] ^ w_c1;
  assign w_cout = (r_a[1] & r_b[1]) | (r_a[1] & w_c1) | (r_b[1] & w_c1);
  assign w_last = (r_idx == c_LAST);

  // Result fills from the top; after N slices the LSB pair has reached bit 0.
  generate
    if (WIDTH == 2) begin : g_sum_w2
      assign w_sum_next = {w_s1, w_s0};
    end else begin : g_sum_wide
      assign w_sum_next = {w_s1, w_s0, r_sum[WIDTH-1:2]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (clr) begin
      r_state <= c_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_a     <= r_a >> 2;
          r_b     <= r_b >> 2;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_cout  <= w_cout;
            r_state <= c_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // Carry into the MSB equals a1^b1^s1, i.e. the slice-internal carry w_c1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if ((r_state == c_RUN) && w_last) begin
      r_ovf <= w_cout ^ w_c1;
    end
  end

  assign out_ovf = r_ovf;
`endif

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign busy      = (r_state != c_IDLE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder2_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder2_seq
// Purpose  : Scoreboard bench for serial_adder2_seq (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_serial_adder2_seq;

  localparam int c_N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       busy;
`ifdef SERIAL_ADD_OVF_EN
  logic       out_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] sb[$];   // {ovf, cout, sum}
  bit rand_done = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vecs[12] = '{
    '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1},
    '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
    '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0},
    '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0},
    '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1},
    '{8'h9C, 8'h9C, 1'b0, 8'h38, 1'b1, 1'b1}
  };

  serial_adder2_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares at the negedge preceding each output handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("sum", {24'd0, out_sum}, {24'd0, e[7:0]});
        chk("cout", {31'd0, out_cout}, {31'd0, e[8]});
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", {31'd0, out_ovf}, {31'd0, e[9]});
`endif
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input bit lat);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    sb.push_back({eo, ec, es});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin;   // must not disturb the registered operands
    if (lat) begin
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("in_ready_in_run", {31'd0, in_ready}, 32'd0);
      for (int k = 1; k < c_N; k++) begin
        @(posedge clk); #1;
        chk("out_valid_early", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, out_sum}, 32'd0);
    chk("rst_cout", {31'd0, out_cout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, latency checked on the first
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o, (i == 0));
      drain();
    end

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    send(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(posedge clk); #1; t++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {24'd0, out_sum}, 32'h7F);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Async reset at idx=2
    send(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_sum", {24'd0, out_sum}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Synchronous clear at idx=1
    send(8'h77, 8'h11, 1'b1, 8'h89, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    sb.delete();
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);

    // clr wins over in_valid in IDLE
    in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("clr_beats_valid", {31'd0, busy}, 32'd0);

    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomised operands and handshake gaps against an arithmetic model
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [7:0] a, b, lo;
          logic       cin;
          logic [8:0] full;
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
          full = 9'(a) + 9'(b) + 9'(cin);
          lo   = 8'(a[6:0]) + 8'(b[6:0]) + 8'(cin);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send(a, b, cin, full[7:0], full[8], full[8] ^ lo[7], 1'b0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
